// File: rtl/system_top_pkg.sv
// Shared constants, command FSM states and baud helper for the UART command shell.
package system_top_pkg;

    localparam logic [7:0] CMD_GPIO = 8'h47;
    localparam logic [7:0] CMD_LED  = 8'h4C;
    localparam logic [7:0] CMD_READ = 8'h52;
    localparam logic [7:0] ACK      = 8'h06;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GPIO,
        WAIT_LED
    } cmd_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/system_top_if.sv
// Byte-level link between the UART and the command core: received bytes up, reply bytes down.
interface system_top_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_push;
    logic [7:0] tx_data;

    modport master (input rx_valid, rx_data, output tx_push, tx_data);
    modport slave  (output rx_valid, rx_data, input tx_push, tx_data);
endinterface

// File: rtl/sys_uart.sv
// 8N1 UART: rxd synchronizer + receiver, 2-entry reply FIFO and transmit serializer.
module sys_uart
    import system_top_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    system_top_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic            sync1_q, sync2_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic            rx_armed_q, rx_armed_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid;

    logic [1:0][7:0] fifo_q, fifo_d;
    logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    logic            do_push, do_pop;
    logic            tx_busy_q, tx_busy_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic            txd_q, txd_d;

    // Receiver only arms after seeing an idle-high line, so a stuck-low line never yields bytes.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_armed_d = rx_armed_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (sync2_q) rx_armed_d = 1'b1;
                else if (rx_armed_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_state_d = RX_IDLE;
                if (sync2_q) rx_valid   = 1'b1;
                else         rx_armed_d = 1'b0;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Serializer reloads straight from the FIFO at the end of a stop bit, giving gapless frames.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        do_pop     = 1'b0;
        if (!tx_busy_q || (tx_cnt_q == BIT_LAST && tx_bit_q == 4'd9)) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (fifo_cnt_q != 2'd0) begin
                do_pop     = 1'b1;
                tx_busy_d  = 1'b1;
                tx_shift_d = {1'b1, fifo_q[rd_ptr_q]};
                txd_d      = 1'b0;
            end else begin
                tx_busy_d  = 1'b0;
                txd_d      = 1'b1;
            end
        end else if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d   = '0;
            tx_bit_d   = tx_bit_q + 1'b1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
        end
    end

    always_comb begin
        do_push = bus.tx_push && (fifo_cnt_q != 2'd2);
        fifo_d  = fifo_q;
        if (do_push) fifo_d[wr_ptr_q] = bus.tx_data;
        wr_ptr_d   = wr_ptr_q ^ do_push;
        rd_ptr_d   = rd_ptr_q ^ do_pop;
        fifo_cnt_d = fifo_cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_armed_q <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            txd_q      <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            rx_armed_q <= rx_armed_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign txd          = txd_q;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_data  = rx_shift_q;

endmodule

// File: rtl/system_top_wrapper.sv
// Board shell: UART command decoder driving GPIO and LED registers.
// Define SYSTOP_HEARTBEAT_EN to turn the top LED into a 2^24-cycle heartbeat.
module system_top_wrapper
    import system_top_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int GPIO_W = 8,
    parameter int LED_W  = 4
) (
    input  logic              clk_50M,
    input  logic              k_resetb,
    input  logic              uart_rtl_0_rxd,
    output logic              uart_rtl_0_txd,
    output logic [GPIO_W-1:0] gpio_tri_o,
    output logic [LED_W-1:0]  gpio_led
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    system_top_if bus ();

    sys_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk (clk_50M),
        .rst (k_resetb),
        .rxd (uart_rtl_0_rxd),
        .txd (uart_rtl_0_txd),
        .bus (bus)
    );

    cmd_state_e        state_q, state_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              tx_push;
    logic [7:0]        tx_data;
`ifdef SYSTOP_HEARTBEAT_EN
    logic [23:0]       hb_cnt_q, hb_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        gpio_d  = gpio_q;
        led_d   = led_q;
        tx_push = 1'b0;
        tx_data = 8'h00;
`ifdef SYSTOP_HEARTBEAT_EN
        hb_cnt_d = hb_cnt_q + 1'b1;
        if (&hb_cnt_q) led_d[LED_W-1] = ~led_q[LED_W-1];
`endif
        if (bus.rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_data == CMD_GPIO)     state_d = WAIT_GPIO;
                    else if (bus.rx_data == CMD_LED) state_d = WAIT_LED;
                    else begin
                        tx_push = 1'b1;
                        tx_data = (bus.rx_data == CMD_READ) ? 8'(gpio_q) : bus.rx_data;
                    end
                end
                WAIT_GPIO: begin
                    gpio_d  = bus.rx_data[GPIO_W-1:0];
                    tx_push = 1'b1;
                    tx_data = ACK;
                    state_d = IDLE;
                end
                WAIT_LED: begin
`ifdef SYSTOP_HEARTBEAT_EN
                    led_d[LED_W-2:0] = bus.rx_data[LED_W-2:0];
`else
                    led_d = bus.rx_data[LED_W-1:0];
`endif
                    tx_push = 1'b1;
                    tx_data = ACK;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (k_resetb) begin
            state_q  <= IDLE;
            gpio_q   <= '0;
            led_q    <= '0;
`ifdef SYSTOP_HEARTBEAT_EN
            hb_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gpio_q   <= gpio_d;
            led_q    <= led_d;
`ifdef SYSTOP_HEARTBEAT_EN
            hb_cnt_q <= hb_cnt_d;
`endif
        end
    end

    assign bus.tx_push = tx_push;
    assign bus.tx_data = tx_data;
    assign gpio_tri_o  = gpio_q;
    assign gpio_led    = led_q;

endmodule

// File: tb/tb_system_top_wrapper.sv
// Randomized scoreboard bench: serial stimulus on rxd, independent txd frame decoder as monitor.
module tb_system_top_wrapper;
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 3_125_000;
    localparam int CPB    = 16;
`ifdef SYSTOP_HEARTBEAT_EN
    localparam logic [3:0] LED_MASK = 4'h7;
`else
    localparam logic [3:0] LED_MASK = 4'hF;
`endif

    logic       clk_50M = 1'b0;
    logic       k_resetb = 1'b1;
    logic       rxd = 1'b0;
    logic       txd;
    logic [7:0] gpio;
    logic [3:0] led;

    always #10 clk_50M = ~clk_50M;

    system_top_wrapper #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GPIO_W(8), .LED_W(4)) dut (
        .clk_50M        (clk_50M),
        .k_resetb       (k_resetb),
        .uart_rtl_0_rxd (rxd),
        .uart_rtl_0_txd (txd),
        .gpio_tri_o     (gpio),
        .gpio_led       (led)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b1;
    bit         mon_busy = 1'b0;
    int         m_state = 0;   // 0 idle, 1 expecting GPIO byte, 2 expecting LED byte
    logic [7:0] gpio_m = '0;
    logic [3:0] led_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_state)
            1: begin gpio_m = b; exp_q.push_back(8'h06); m_state = 0; end
            2: begin led_m = b[3:0] & LED_MASK; exp_q.push_back(8'h06); m_state = 0; end
            default: begin
                if (b == 8'h47)      m_state = 1;
                else if (b == 8'h4C) m_state = 2;
                else if (b == 8'h52) exp_q.push_back(gpio_m);
                else                 exp_q.push_back(b);
            end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        if (good) model_byte(b);
        @(negedge clk_50M) rxd = 1'b0;
        repeat (CPB) @(negedge clk_50M);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk_50M);
        end
        rxd = good;
        repeat (CPB) @(negedge clk_50M);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk_50M);
        check("gpio", gpio, gpio_m);
        check("led", led & LED_MASK, led_m);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 40 * CPB) begin
            @(negedge clk_50M);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_50M) k_resetb = 1'b1;
        @(negedge clk_50M) k_resetb = 1'b0;
        check("rst_txd", txd, 1);
        check("rst_gpio", gpio, 0);
        check("rst_led", led, 0);
        exp_q.delete();
        m_state = 0;
        gpio_m  = '0;
        led_m   = '0;
    endtask

    // Monitor: decode every txd frame at bit centres and score it against the queue.
    initial begin : monitor
        logic [7:0] b;
        logic       st, sp;
        forever begin
            @(negedge clk_50M);
            if (txd === 1'b0) begin
                mon_busy = 1'b1;
                repeat (CPB / 2) @(negedge clk_50M);
                st = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_50M);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk_50M);
                sp = txd;
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got byte %02h expected none", b);
                    end else begin
                        check("tx_byte", b, exp_q.pop_front());
                        check("tx_start", st, 0);
                        check("tx_stop", sp, 1);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stim
        logic [7:0] rb;
        int         sel;
        repeat (3) @(negedge clk_50M);
        k_resetb = 1'b0;
        check("rst_txd", txd, 1);
        check("rst_gpio", gpio, 0);
        check("rst_led", led, 0);

        // Line stuck low from reset: nothing may happen.
        for (int i = 0; i < 100 * CPB; i++) begin
            @(negedge clk_50M);
            check("low_txd_idle", txd, 1);
        end
        check("low_gpio", gpio, 0);
        check("low_led", led, 0);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk_50M);

        send_byte(8'h41, 1'b1);
        send_byte(8'h4C, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h47, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h52, 1'b1);
        wait_drain();

        // Framing error on a command byte must not advance the decoder.
        send_byte(8'h47, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_drain();

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            rb  = 8'($urandom);
            case (sel)
                0, 1:    send_byte(8'h47, 1'b1);
                2, 3:    send_byte(8'h4C, 1'b1);
                4:       send_byte(8'h52, 1'b1);
                5:       send_byte(rb, 1'b0);
                default: send_byte(rb, 1'b1);
            endcase
        end
        wait_drain();

        // Reset while a reply frame is on the wire.
        send_byte(8'h47, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h4C, 1'b1);
        send_byte(8'h0A, 1'b1);
        wait_drain();
        mon_en = 1'b0;
        send_byte(8'h41, 1'b1);
        pulse_reset();
        for (int i = 0; i < 20 * CPB; i++) begin
            @(negedge clk_50M);
            check("post_rst_txd_idle", txd, 1);
        end
        mon_en = 1'b1;

        // Reset while the decoder waits for a GPIO operand.
        send_byte(8'h47, 1'b1);
        pulse_reset();
        repeat (2 * CPB) @(negedge clk_50M);
        send_byte(8'h33, 1'b1);
        send_byte(8'h52, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
